seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//   Parametrised serial bit-pattern detector, successor to the fixed "11" Mealy detector.
//   Pattern, length, overlap policy and output timing (Mealy/Moore) are set by parameter.
//   A qualifier input gates bit acceptance, and a saturating match counter is provided.
//   Sits on a 1-bit serial stream inside the FSM block library; y feeds downstream event logic.
// PARAMETERS
//   PAT_W    4        pattern length in bits, 1..16
//   PATTERN  4'b1011  target pattern; MSB is the oldest bit received, LSB the newest
//   OVERLAP  1        1 = overlapping matches allowed; 0 = history discarded after a match
//   MOORE    0        0 = Mealy (y combinational, same cycle); 1 = Moore (y registered, +1 cycle)
//   CNT_W    8        width of the match counter
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   x_valid    in   1      x is sampled only when high
//   x          in   1      serial data bit
//   clr_cnt    in   1      synchronous clear of match_cnt
//   y          out  1      match indication
//   match_cnt  out  CNT_W  number of matches since reset/clear, saturating
// BEHAVIOUR
//   - State:
//     - hist: shift register holding the last PAT_W-1 accepted bits (no register when PAT_W=1).
//     - fill: count of valid history bits, 0..PAT_W-1.
//   - Accept: on a clk edge with x_valid=1, hist <= {hist, x} (oldest bit dropped).
//     fill increments and saturates at PAT_W-1.
//   - hit = x_valid & (fill == PAT_W-1) & ({hist, x} == PATTERN).
//     - No match is possible until PAT_W bits have been accepted since reset or flush.
//   - OVERLAP=0: on hit, fill <= 0 in place of the shift. The next match needs PAT_W fresh bits.
//   - OVERLAP=1: on hit, shift proceeds normally, so a suffix of one match can start the next.
//   - x_valid=0: hist and fill hold; hit=0.
//   - Mealy (MOORE=0): y = hit, combinational in the same cycle the completing bit is presented.
//   - Moore (MOORE=1): y_q <= hit and y = y_q.
//     - y rises the cycle after the completing bit and stays high exactly one cycle per hit.
//     - Back-to-back hits keep y high on consecutive cycles.
//   - match_cnt, evaluated at each clk edge:
//     - clr_cnt=1: match_cnt <= 0. Clear has priority; a simultaneous hit is not counted.
//     - else if hit and match_cnt != all-ones: match_cnt <= match_cnt + 1.
//     - At all-ones the counter holds. No wrap.
//   - Reset (rst=1 at a clk edge): hist=0, fill=0, y_q=0, match_cnt=0.
//     - Mealy y is forced to 0 while rst=1.
//     - Reset mid-pattern discards partial history; the first post-reset match needs PAT_W new bits.
//   - Reset dominates x_valid and clr_cnt.
//   - PAT_W=1: hit = x_valid & (x == PATTERN[0]) every accepted cycle. OVERLAP has no effect.
// TESTING
//   1. PAT_W=2, PATTERN=2'b11, Mealy, OVERLAP=1; stream 0,1,1,1 (x_valid=1)
//      -> y=1 on bits 3 and 4; match_cnt=2.
//   2. Same stream with OVERLAP=0 -> y=1 on bit 3 only; match_cnt=1.
//   3. Default params, stream 1,0,1,1,0,1,1
//      -> OVERLAP=1: y on bits 4 and 7 (cnt=2); OVERLAP=0: y on bit 4 only (cnt=1).
//   4. MOORE=1, PATTERN=4'b1011, stream 1,0,1,1
//      -> y=0 during bit 4; y=1 for exactly the following cycle; then 0.
//   5. Bubbles: 1,0,(x_valid=0 for 3 cycles, x=1),1,1
//      -> single match on the final bit; hist frozen during the bubble.
//   6. Shift 1,0,1; pulse rst; then 1 -> no match.
//      CNT_W=2 with 5 matches -> match_cnt=3.
//      clr_cnt coincident with a hit -> match_cnt=0.

Source files
------------

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Parametrised serial bit-pattern detector. Accepted bits (x_valid=1) are
//   shifted into a short history; a hit is flagged when the last PAT_W
//   accepted bits equal PATTERN (MSB = oldest). Overlap policy and Mealy /
//   Moore output timing are chosen by parameter. A saturating counter
//   tallies hits since reset or the last clr_cnt.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   x_valid    in   1      qualifies x; history frozen while low
//   x          in   1      serial data bit
//   clr_cnt    in   1      synchronous clear of match_cnt (beats a hit)
//   y          out  1      match indication (Mealy: same cycle, Moore: +1)
//   match_cnt  out  CNT_W  saturating match count
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter bit               MOORE   = 1'b0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic hit;

  generate
    if (PAT_W == 1) begin : g_single
      // A single-bit pattern needs no history: every accepted bit is judged alone.
      assign hit = x_valid & (x == PATTERN[0]);
    end else begin : g_multi
      localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

      logic [PAT_W-2:0]  hist;
      logic [FILL_W-1:0] fill;
      logic [PAT_W-1:0]  window;
      logic              full;

      assign window = {hist, x};
      assign full   = (fill == FILL_MAX);
      assign hit    = x_valid & full & (window == PATTERN);

      always_ff @(posedge clk) begin
        if (rst) begin
          hist <= '0;
          fill <= '0;
        end else if (x_valid) begin
          if (hit && !OVERLAP) begin
            // Non-overlapping: forget the history. hist is left as is because
            // PAT_W-1 fresh shifts overwrite it before fill is full again.
            fill <= '0;
          end else begin
            hist <= window[PAT_W-2:0];
            if (!full) fill <= fill + FILL_W'(1);
          end
        end
      end
    end
  endgenerate

  generate
    if (MOORE) begin : g_moore
      logic y_p1;

      // Stage p1: hit registered, one-cycle-late pulse per hit
      always_ff @(posedge clk) begin
        if (rst) y_p1 <= 1'b0;
        else     y_p1 <= hit;
      end

      assign y = y_p1;
    end else begin : g_mealy
      assign y = hit & ~rst;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      match_cnt <= '0;
    end else if (hit && !(&match_cnt)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//   Drives one shared stimulus stream into six detector configurations and
//   compares y and match_cnt every cycle against a reference model that
//   works from the accepted-bit stream (bits since last flush plus the
//   recent bits as an integer), then adds directed scenario checks.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst, x_valid, x, clr_cnt;

  always #5 clk = ~clk;

  // Configuration table: 0 default, 1 no-overlap, 2 Moore, 3 "11" overlap
  // with 2-bit counter, 4 "11" no-overlap, 5 single-bit pattern.
  localparam int NDUT = 6;
  int pw   [NDUT] = '{4, 4, 4, 2, 2, 1};
  int pat  [NDUT] = '{11, 11, 11, 3, 3, 1};
  int ov   [NDUT] = '{1, 0, 1, 1, 0, 1};
  int mo   [NDUT] = '{0, 0, 1, 0, 0, 0};
  int cw   [NDUT] = '{8, 8, 8, 2, 8, 3};

  logic       y0, y1, y2, y3, y4, y5;
  logic [7:0] c0, c1, c2, c4;
  logic [1:0] c3;
  logic [2:0] c5;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .clr_cnt(clr_cnt), .y(y0), .match_cnt(c0));
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .clr_cnt(clr_cnt), .y(y1), .match_cnt(c1));
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .clr_cnt(clr_cnt), .y(y2), .match_cnt(c2));
  seq_detector_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .clr_cnt(clr_cnt), .y(y3), .match_cnt(c3));
  seq_detector_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .clr_cnt(clr_cnt), .y(y4), .match_cnt(c4));
  seq_detector_param #(.PAT_W(1), .PATTERN(1'b1), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(3)) u5 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .clr_cnt(clr_cnt), .y(y5), .match_cnt(c5));

  logic [NDUT-1:0] ys;
  int              cs [NDUT];
  assign ys = {y5, y4, y3, y2, y1, y0};
  always_comb begin
    cs[0] = int'(c0);
    cs[1] = int'(c1);
    cs[2] = int'(c2);
    cs[3] = int'(c3);
    cs[4] = int'(c4);
    cs[5] = int'(c5);
  end

  // Reference model state
  int since [NDUT];   // bits accepted since reset or non-overlap flush
  int win   [NDUT];   // recent accepted bits, newest in bit 0
  int cnt   [NDUT];
  int yq    [NDUT];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_hit(input int i, input logic xv, input logic xb);
    int w;
    if (!xv) return 0;
    if (since[i] < pw[i] - 1) return 0;
    w = ((win[i] << 1) | int'(xb)) & ((1 << pw[i]) - 1);
    return (w == pat[i]) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      since[i] = 0; win[i] = 0; cnt[i] = 0; yq[i] = 0;
    end
  endtask

  // One clock cycle: apply inputs, check pre-edge outputs, advance model.
  task automatic step(input logic xv, input logic xb, input logic clr, input logic r);
    int h [NDUT];
    @(negedge clk);
    x_valid = xv; x = xb; clr_cnt = clr; rst = r;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      h[i] = model_hit(i, xv, xb);
      if (mo[i] != 0) check($sformatf("y%0d", i), int'(ys[i]), yq[i]);
      else            check($sformatf("y%0d", i), int'(ys[i]), r ? 0 : h[i]);
      check($sformatf("cnt%0d", i), cs[i], cnt[i]);
    end
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) begin
      if (r) begin
        since[i] = 0; win[i] = 0; cnt[i] = 0; yq[i] = 0;
      end else begin
        if (clr) cnt[i] = 0;
        else if (h[i] != 0 && cnt[i] != (1 << cw[i]) - 1) cnt[i]++;
        yq[i] = h[i];
        if (xv) begin
          if (h[i] != 0 && ov[i] == 0) begin
            since[i] = 0; win[i] = 0;
          end else begin
            since[i]++;
            win[i] = ((win[i] << 1) | int'(xb)) & 16'hFFFF;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic feed(input int n, input logic [15:0] bits);
    for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k], 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; x_valid = 1'b0; x = 1'b0; clr_cnt = 1'b0;
    model_reset();

    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_cnt0", cs[0], 0);
    check("reset_y2", int'(y2), 0);

    // "11" detector on 0,1,1,1
    feed(4, 16'b0111);
    #1;
    check("t1_cnt_ovl", cs[3], 2);
    check("t1_cnt_novl", cs[4], 1);

    // 1011 on 1,0,1,1,0,1,1
    do_reset();
    feed(7, 16'b1011011);
    #1;
    check("t3_cnt_ovl", cs[0], 2);
    check("t3_cnt_novl", cs[1], 1);

    // Moore: completing bit then one-cycle pulse
    do_reset();
    feed(4, 16'b1011);
    #1;
    check("t4_moore_hi", int'(y2), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t4_moore_lo", int'(y2), 0);

    // Bubbles freeze history
    do_reset();
    feed(2, 16'b10);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    feed(2, 16'b11);
    #1;
    check("t5_bubble_cnt", cs[0], 1);

    // Reset mid-pattern discards history
    do_reset();
    feed(3, 16'b101);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(1, 16'b1);
    #1;
    check("t6_rst_mid", cs[0], 0);

    // Saturation of the 2-bit counter: five "11" hits
    do_reset();
    feed(6, 16'b111111);
    #1;
    check("t6_sat", cs[3], 3);

    // Clear coincident with a hit
    do_reset();
    feed(3, 16'b101);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("t6_clr_hit", cs[0], 0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
